// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encrypt/decrypt engine with a cached
// 11-entry round-key store and valid/ready handshakes on both sides.
// UNROLL rounds are applied per clock (1, 2, 5 or 10).
// Optional macro AES_CBC_EN adds CBC chaining (ports iv_load, iv).
module aes128_iter_core #(
    parameter int UNROLL               = 1,
    parameter bit KEY_CACHE_EN_DEFAULT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [0:127] in_data,
    input  logic [0:127] in_key,
    input  logic         key_flush,
`ifdef AES_CBC_EN
    input  logic         iv_load,
    input  logic [0:127] iv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         key_hit,
    output logic         busy
);
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
        $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
    end

    localparam logic [3:0] STEP = 4'(UNROLL);

    typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_WHITEN, S_ROUND, S_DONE} state_t;

    // GF(2^8) arithmetic; S-boxes are derived from the field inverse so no tables are needed
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xt(p);
        end
        return r;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gm(p, p);
            r = gm(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] i;
        i = ginv(x);
        return i ^ rl(i, 1) ^ rl(i, 2) ^ rl(i, 3) ^ rl(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isb(input logic [7:0] y);
        return ginv(rl(y, 1) ^ rl(y, 3) ^ rl(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] a, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        if (inv)
            return {gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09),
                    gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d),
                    gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b),
                    gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e)};
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // State byte 4*c+r (row r, column c) lives at bits [127-8*(4c+r) -: 8]
    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(4*c+r) -: 8] = sb(s[127-8*(4*((c+r)%4)+r) -: 8]);
        if (!last)
            for (int c = 0; c < 4; c++)
                t[127-32*c -: 32] = mix(t[127-32*c -: 32], 1'b0);
        return t ^ k;
    endfunction

    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(4*c+r) -: 8] = isb(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
        t = t ^ k;
        if (!last)
            for (int c = 0; c < 4; c++)
                t[127-32*c -: 32] = mix(t[127-32*c -: 32], 1'b1);
        return t;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
            4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
            4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
            4'd10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sb(k[23:16]), sb(k[15:8]), sb(k[7:0]), sb(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t       r_fsm;
    logic [3:0]   r_cnt;
    logic         r_cache_vld, r_abort, r_mode;
    logic         r_out_valid, r_key_hit;
    logic [127:0] r_data, r_state, r_out_data;
    logic [127:0] r_rk [0:10];
    logic [127:0] r_chain;

    logic [127:0] w_key_in, w_rk_next, w_wh_chain, w_out_chain;
    logic [127:0] w_st [0:UNROLL];
    logic         w_miss;

    assign w_key_in  = in_key;
    assign w_miss    = !KEY_CACHE_EN_DEFAULT || !r_cache_vld || key_flush || (w_key_in != r_rk[0]);
    assign w_rk_next = kexp(r_rk[r_cnt], rcon(r_cnt + 4'd1));

`ifdef AES_CBC_EN
    assign w_wh_chain  = r_mode ? '0 : r_chain;
    assign w_out_chain = r_mode ? r_chain : '0;
`else
    assign r_chain     = '0;
    assign w_wh_chain  = r_chain;
    assign w_out_chain = r_chain;
`endif

    // Round chain: stage j applies round r_cnt+j+1; out-of-range indices only occur outside ROUND
    assign w_st[0] = r_state;
    for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
        logic [4:0] w_n;
        logic [3:0] w_ki;
        assign w_n  = {1'b0, r_cnt} + 5'(j + 1);
        assign w_ki = (w_n > 5'd10) ? 4'd0 : (r_mode ? 4'(5'd10 - w_n) : w_n[3:0]);
        assign w_st[j+1] = r_mode ? dec_round(w_st[j], r_rk[w_ki], w_n == 5'd10)
                                  : enc_round(w_st[j], r_rk[w_ki], w_n == 5'd10);
    end

    // Control FSM, key store, datapath state and registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= S_IDLE;
            r_cnt       <= '0;
            r_cache_vld <= 1'b0;
            r_abort     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_key_hit   <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: if (in_valid) begin
                    r_data    <= in_data;
                    r_mode    <= in_decrypt;
                    r_key_hit <= !w_miss;
                    r_cnt     <= '0;
                    if (w_miss) begin
                        r_rk[0]     <= in_key;
                        r_cache_vld <= 1'b0;
                        r_abort     <= 1'b0;
                        r_fsm       <= S_KEYEXP;
                    end else begin
                        r_fsm <= S_WHITEN;
                    end
                end
                S_KEYEXP: begin
                    r_rk[r_cnt + 4'd1] <= w_rk_next;
                    r_cnt <= r_cnt + 4'd1;
                    // a flush seen during expansion keeps the store from being claimed as cached
                    if (r_cnt == 4'd9) begin
                        r_cache_vld <= !r_abort;
                        r_fsm       <= S_WHITEN;
                    end
                end
                S_WHITEN: begin
                    r_state <= r_data ^ (r_mode ? r_rk[10] : r_rk[0]) ^ w_wh_chain;
                    r_cnt   <= '0;
                    r_fsm   <= S_ROUND;
                end
                S_ROUND: begin
                    r_state <= w_st[UNROLL];
                    r_cnt   <= r_cnt + STEP;
                    if (r_cnt + STEP == 4'd10) r_fsm <= S_DONE;
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_out_data  <= r_state ^ w_out_chain;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
            // flush wins over any cache-valid update above
            if (key_flush) begin
                r_cache_vld <= 1'b0;
                if (r_fsm == S_KEYEXP) r_abort <= 1'b1;
            end
        end
    end

`ifdef AES_CBC_EN
    // CBC chain register: IV load in IDLE, feedback at the output handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= '0;
        end else if (r_fsm == S_IDLE && iv_load) begin
            r_chain <= iv;
        end else if (r_fsm == S_DONE && r_out_valid && out_ready) begin
            r_chain <= r_mode ? r_data : r_out_data;
        end
    end
`endif

    assign in_ready  = (r_fsm == S_IDLE);
    assign busy      = (r_fsm != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign key_hit   = r_key_hit;
endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core: four cores (UNROLL 1/5/10, and UNROLL 1
// with caching disabled) share one stimulus stream and are checked against
// FIPS-197 / SP800-38A vectors. Build with AES_CBC_EN for the CBC tests.
`timescale 1ns/1ps
module tb_aes128_iter_core;
    localparam logic [0:127] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PTB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] IVC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PC1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [0:127] CC1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [0:127] PC2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [0:127] CC2 = 128'h5086cb9b507219ee95db113a917678b2;

    logic         clk = 1'b0, reset = 1'b1;
    logic         in_valid = 1'b0, in_decrypt = 1'b0, key_flush = 1'b0, out_ready = 1'b1;
    logic [0:127] in_data = '0, in_key = '0;
    logic         iv_load = 1'b0;
    logic [0:127] iv = '0;
    wire  [3:0]   ir, ov, kh, bz;
    wire  [0:127] od [4];

    int           n_chk = 0, n_err = 0;
    int           lat [4];
    logic [0:127] res [4];
    logic [3:0]   seen;
    logic [0:127] hold;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int U = (g == 1) ? 5 : (g == 2) ? 10 : 1;
        aes128_iter_core #(.UNROLL(U), .KEY_CACHE_EN_DEFAULT(g != 3)) u_dut (
            .clk(clk), .reset(reset),
            .in_valid(in_valid), .in_ready(ir[g]), .in_decrypt(in_decrypt),
            .in_data(in_data), .in_key(in_key), .key_flush(key_flush),
`ifdef AES_CBC_EN
            .iv_load(iv_load), .iv(iv),
`endif
            .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]),
            .key_hit(kh[g]), .busy(bz[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One request to all cores; records each core's latency and first result.
    // fl_acc: flush with the accept; fl_at/rst_at: cycle after accept (-1 = never).
    task automatic xfer(input logic dec, input logic [0:127] d, input logic [0:127] k,
                        input logic ld_iv, input logic [0:127] ivv,
                        input logic fl_acc, input int fl_at, input int rst_at);
        @(negedge clk);
        chk("accept_ready", ir, 4'hf);
        in_valid = 1'b1; in_decrypt = dec; in_data = d; in_key = k;
        key_flush = fl_acc; iv_load = ld_iv; iv = ivv;
        seen = '0;
        for (int g = 0; g < 4; g++) lat[g] = -1;
        for (int n = 0; n < 40 && seen != 4'hf; n++) begin
            @(negedge clk);
            in_valid = 1'b0; iv_load = 1'b0;
            key_flush = (fl_at == n);
            reset = (rst_at == n);
            if (rst_at >= 0 && n == rst_at + 1) chk("rst_in_ready", ir, 4'hf);
            for (int g = 0; g < 4; g++)
                if (ov[g] && !seen[g]) begin
                    seen[g] = 1'b1; lat[g] = n; res[g] = od[g];
                end
        end
        if (rst_at < 0) chk("all_done", seen, 4'hf);
        else            chk("no_valid_after_rst", seen[0], 1'b0);
        @(negedge clk);
        reset = 1'b0; key_flush = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", ir, 4'hf);
        chk("rst_out_valid", ov, 4'h0);
        chk("rst_key_hit", kh, 4'h0);
        chk("rst_busy", bz, 4'h0);
        chk("rst_out_data0", od[0], '0);
        chk("rst_out_data2", od[2], '0);
        reset = 1'b0;

        // FIPS-197 C.1, cold cache
        xfer(1'b0, PT1, K1, 1'b1, '0, 1'b0, -1, -1);
        chk("c1_enc_data", res[0], CT1);
        chk("c1_enc_lat", lat[0], 22);
        chk("c1_enc_hit", kh, 4'h0);
        chk("c1_u5_data", res[1], CT1);
        chk("c1_u5_lat", lat[1], 14);
        chk("c1_u10_data", res[2], CT1);
        chk("c1_u10_lat", lat[2], 13);
        chk("c1_nc_data", res[3], CT1);

        // same key, decrypt: hit except on the cache-disabled core
        xfer(1'b1, CT1, K1, 1'b1, '0, 1'b0, -1, -1);
        chk("c1_dec_data", res[0], PT1);
        chk("c1_dec_lat", lat[0], 12);
        chk("c1_dec_hit", kh, 4'b0111);
        chk("c1_dec_nc_lat", lat[3], 22);
        chk("c1_dec_u10", res[2], PT1);

        // FIPS-197 B: miss, then hit latencies per UNROLL
        xfer(1'b0, PTB, KB, 1'b1, '0, 1'b0, -1, -1);
        chk("b_miss_data", res[0], CTB);
        xfer(1'b0, PTB, KB, 1'b1, '0, 1'b0, -1, -1);
        chk("b_hit", kh, 4'b0111);
        chk("b_u1_lat", lat[0], 12);
        chk("b_u5_data", res[1], CTB);
        chk("b_u5_lat", lat[1], 4);
        chk("b_u10_data", res[2], CTB);
        chk("b_u10_lat", lat[2], 3);
        xfer(1'b1, CTB, KB, 1'b1, '0, 1'b0, -1, -1);
        chk("b_u5_dec", res[1], PTB);

        // backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_decrypt = 1'b0; in_data = PT1; in_key = K1; iv_load = 1'b1; iv = '0;
        @(negedge clk);
        in_valid = 1'b0; iv_load = 1'b0;
        for (int n = 0; n < 40 && ov != 4'hf; n++) @(negedge clk);
        chk("bp_valid", ov, 4'hf);
        hold = od[0];
        chk("bp_data", hold, CT1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_stable", od[0], hold);
            chk("bp_in_ready", ir, 4'h0);
            chk("bp_valid_hold", ov, 4'hf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", {ir, bz, ov}, {4'hf, 4'h0, 4'h0});

        // flush during expansion: the resubmitted key must miss and still be correct
        xfer(1'b0, PTB, KB, 1'b1, '0, 1'b0, 3, -1);
        xfer(1'b0, PTB, KB, 1'b1, '0, 1'b0, -1, -1);
        chk("fl_resub_hit", kh, 4'h0);
        chk("fl_resub_data", res[0], CTB);
        chk("fl_resub_lat", lat[0], 22);

        // flush coincident with accept forces a miss on a warm cache
        xfer(1'b0, PTB, KB, 1'b1, '0, 1'b1, -1, -1);
        chk("fl_acc_hit", kh, 4'h0);
        chk("fl_acc_lat", lat[0], 22);
        chk("fl_acc_data", res[0], CTB);

        // reset during ROUND drops the transaction and invalidates the cache
        xfer(1'b0, PTB, KB, 1'b1, '0, 1'b0, -1, 4);
        xfer(1'b0, PTB, KB, 1'b1, '0, 1'b0, -1, -1);
        chk("rst_next_hit", kh[0], 1'b0);
        chk("rst_next_lat", lat[0], 22);
        chk("rst_next_data", res[0], CTB);

`ifdef AES_CBC_EN
        // SP800-38A F.2.1 / F.2.2, first two blocks
        xfer(1'b0, PC1, KB, 1'b1, IVC, 1'b0, -1, -1);
        chk("cbc_enc1", res[0], CC1);
        chk("cbc_enc1_u10", res[2], CC1);
        xfer(1'b0, PC2, KB, 1'b0, '0, 1'b0, -1, -1);
        chk("cbc_enc2", res[0], CC2);
        xfer(1'b1, CC1, KB, 1'b1, IVC, 1'b0, -1, -1);
        chk("cbc_dec1", res[0], PC1);
        xfer(1'b1, CC2, KB, 1'b0, '0, 1'b0, -1, -1);
        chk("cbc_dec2", res[0], PC2);
        chk("cbc_dec2_u5", res[1], PC2);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
